// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: requester, lock, ack and memory-side signals of the data-memory arbiter
interface dmem_arbiter_if #(parameter int ADDR_W = 10, parameter int DATA_W = 32);
  logic              req0, we0, req1, we1, lock0, lock1;
  logic              ack0, ack1, mem_en, mem_we, busy;
  logic [ADDR_W-1:0] addr0, addr1, mem_addr;
  logic [DATA_W-1:0] wdata0, wdata1, rdata, mem_wdata, mem_rdata;
  modport slave (
    input  req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, lock0, lock1, mem_rdata,
    output ack0, ack1, rdata, mem_en, mem_we, mem_addr, mem_wdata, busy
  );
  modport master (
    output req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, lock0, lock1, mem_rdata,
    input  ack0, ack1, rdata, mem_en, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin two-port arbiter for the single-port data memory, IDLE->ACCESS->RESP.
// Define ARB_LOCK_EN to let a winner hold the bus for up to LOCK_MAX consecutive grants.
module dmem_arbiter #(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 32,
  parameter int LOCK_MAX = 8
) (
  input logic          clk,
  input logic          reset,
  dmem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t            state, state_n;
  logic              sel, last_grant, we_q, go, pick;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
`ifdef ARB_LOCK_EN
  localparam int CW = $clog2(LOCK_MAX + 1);
  logic          locked, lock_port, lk;
  logic [CW-1:0] lock_cnt, cnt_n;
  assign lk    = sel ? bus.lock1 : bus.lock0;
  assign cnt_n = locked ? lock_cnt + 1'b1 : CW'(1);
  // a lock survives idle cycles; it ends when the winner drops lock or hits LOCK_MAX grants
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      locked    <= 1'b0;
      lock_port <= 1'b0;
      lock_cnt  <= '0;
    end else if (state == RESP) begin
      locked    <= lk && cnt_n != CW'(LOCK_MAX);
      lock_port <= sel;
      lock_cnt  <= (lk && cnt_n != CW'(LOCK_MAX)) ? cnt_n : '0;
    end
`else
  logic unused_lock;
  assign unused_lock = bus.lock0 ^ bus.lock1 ^ (LOCK_MAX == 0);
`endif
  always_comb begin
    pick = (bus.req0 && bus.req1) ? ~last_grant : bus.req1;
    go   = bus.req0 | bus.req1;
`ifdef ARB_LOCK_EN
    pick = locked ? lock_port : pick;
    go   = locked ? (lock_port ? bus.req1 : bus.req0) : go;
`endif
    state_n = state == IDLE ? (go ? ACCESS : IDLE) : state == ACCESS ? RESP : IDLE;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state      <= IDLE;
      sel        <= 1'b0;
      last_grant <= 1'b1;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && go) begin
        sel     <= pick;
        we_q    <= pick ? bus.we1 : bus.we0;
        addr_q  <= pick ? bus.addr1 : bus.addr0;
        wdata_q <= pick ? bus.wdata1 : bus.wdata0;
      end
      if (state == RESP) last_grant <= sel;
    end
  // memory output is already registered, so gating it in RESP keeps rdata stable with ack
  assign bus.mem_en    = state == ACCESS;
  assign bus.mem_we    = bus.mem_en & we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.ack0      = state == RESP && !sel;
  assign bus.ack1      = state == RESP && sel;
  assign bus.rdata     = (state == RESP && !we_q) ? bus.mem_rdata : '0;
  assign bus.busy      = state != IDLE;
endmodule
